// File: rtl/tl_xbar_pkg.sv
// rtl/tl_xbar_pkg.sv - shared constants and width helper for the demux buffer
// Contents:
//   ERR_CNT_MAX : saturation value of the dropped-beat counter
//   cw_of()     : occupancy-count width for a buffer of a given depth
package tl_xbar_pkg;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // The width must hold values 0..depth inclusive, so one more than the depth.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tl_sync_fifo.sv
// rtl/tl_sync_fifo.sv - single-clock FIFO with occupancy count and sync clear
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   clear            : synchronous empty; overrides push and pop
//   push, push_data  : write request and payload (ignored when full)
//   pop              : read request (ignored when empty)
//   full, empty      : derived from the occupancy count
//   level            : occupancy, 0..DEPTH
//   head             : oldest entry, meaningful when not empty
module tl_sync_fifo
    import tl_xbar_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [cw_of(DEPTH)-1:0]    level,
    output logic [DATA_W-1:0]          head
);

    localparam int CW = cw_of(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     level_q,  level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Pointers alone cannot tell full from empty, so the count decides both.
    assign empty   = (level_q == '0);
    assign full    = (level_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tl_demux_buf.sv
// rtl/tl_demux_buf.sv - one-to-N demultiplexer with a small FIFO per output
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   valid_i/ready_o/data_i    : input beat handshake and payload
//   sel_i                     : destination port; indices >= N are dropped
//   flush_i                   : synchronous clear of all buffers and err_cnt_o
//   valid_o/ready_i/data_o    : per-port head handshake and payload
//   level_o                   : per-port occupancy, CW bits per port
//   err_o                     : one-cycle pulse after a dropped beat
//   err_cnt_o                 : saturating dropped-beat count
module tl_demux_buf
    import tl_xbar_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [SEL_W-1:0]             sel_i,
    input  logic                         flush_i,
    output logic [N-1:0]                 valid_o,
    input  logic [N-1:0]                 ready_i,
    output logic [N*DATA_W-1:0]          data_o,
    output logic [N*cw_of(DEPTH)-1:0]    level_o,
    output logic                         err_o,
    output logic [7:0]                   err_cnt_o
);

    localparam int CW = cw_of(DEPTH);

    logic [N-1:0]      full;
    logic [N-1:0]      empty;
    logic [N-1:0]      push;
    logic [N-1:0]      pop;
    logic              sel_hit;
    logic              sel_full;
    logic              accept;
    logic              drop;
    logic              err_q,     err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // ready_o looks only at the selected buffer's full flag, never at ready_i,
    // so a full buffer cannot be bypassed by a same-cycle pop.
    always_comb begin
        sel_hit  = 1'b0;
        sel_full = 1'b0;
        push     = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_hit  = 1'b1;
                sel_full = full[k];
            end
        end
        if (flush_i) begin
            ready_o = 1'b0;
        end else if (sel_hit) begin
            ready_o = !sel_full;
        end else begin
            ready_o = 1'b1;
        end
        accept = valid_i && ready_o;
        for (int k = 0; k < N; k++) begin
            push[k] = accept && (sel_i == SEL_W'(k));
        end
        drop = accept && !sel_hit;
    end

    always_comb begin
        err_d     = drop;
        err_cnt_d = err_cnt_q;
        if (flush_i) begin
            err_cnt_d = '0;
        end else if (drop && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

    for (genvar k = 0; k < N; k++) begin : g_port
        assign valid_o[k] = !empty[k];
        assign pop[k]     = ready_i[k] && !empty[k];

        tl_sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush_i),
            .push      (push[k]),
            .push_data (data_i),
            .pop       (pop[k]),
            .full      (full[k]),
            .empty     (empty[k]),
            .level     (level_o[k*CW +: CW]),
            .head      (data_o[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_tl_demux_buf.sv
// tb/tb_tl_demux_buf.sv - self-checking bench for tl_demux_buf
module tb_tl_demux_buf;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int DEPTH  = 2;
    localparam int CW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [DATA_W-1:0]    data_i = '0;
    logic [SEL_W-1:0]     sel_i = '0;
    logic                 flush_i = 1'b0;
    logic [N-1:0]         valid_o;
    logic [N-1:0]         ready_i = '0;
    logic [N*DATA_W-1:0]  data_o;
    logic [N*CW-1:0]      level_o;
    logic                 err_o;
    logic [7:0]           err_cnt_o;

    int tests = 0;
    int fails = 0;

    tl_demux_buf #(.N(N), .DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .sel_i(sel_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .level_o(level_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per port plus the error state.
    logic [7:0] mq [N][$];
    int         m_cnt = 0;
    logic       m_err = 1'b0;

    function automatic logic m_ready();
        if (flush_i) return 1'b0;
        if (int'(sel_i) < N) return mq[int'(sel_i)].size() < DEPTH;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            automatic logic acc = valid_i && m_ready();
            if (flush_i) begin
                for (int k = 0; k < N; k++) mq[k].delete();
                m_cnt = 0;
                m_err = 1'b0;
            end else begin
                for (int k = 0; k < N; k++)
                    if (ready_i[k] && mq[k].size() > 0) void'(mq[k].pop_front());
                if (acc && int'(sel_i) < N) mq[int'(sel_i)].push_back(data_i);
                m_err = acc && (int'(sel_i) >= N);
                if (m_err && m_cnt < 255) m_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            check($sformatf("valid_o[%0d]", k), 32'(valid_o[k]), 32'(mq[k].size() > 0));
            check($sformatf("level[%0d]", k), 32'(level_o[k*CW +: CW]), 32'(mq[k].size()));
            if (mq[k].size() > 0)
                check($sformatf("data[%0d]", k), 32'(data_o[k*DATA_W +: DATA_W]), 32'(mq[k][0]));
        end
        check("err_o", 32'(err_o), 32'(m_err));
        check("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
        check("ready_o", 32'(ready_o), 32'(m_ready()));
    end

    // Drive inputs, let one rising edge pass, return 2 time units after it.
    task automatic cyc(input logic v, input int sel, input logic [7:0] d,
                       input logic [3:0] rdy, input logic fl);
        valid_i = v;
        sel_i   = SEL_W'(sel);
        data_i  = d;
        ready_i = rdy;
        flush_i = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        cyc(0, 0, 8'h00, 4'hF, 0);
        cyc(0, 0, 8'h00, 4'hF, 0);
    endtask

    initial begin
        sel_i = 3'd7;
        #1;
        check("rst valid_o", 32'(valid_o), 32'h0);
        check("rst level_o", 32'(level_o), 32'h0);
        check("rst err_o", 32'(err_o), 32'h0);
        check("rst err_cnt_o", 32'(err_cnt_o), 32'h0);
        check("rst ready_o sel7", 32'(ready_o), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single beat to port 0, one cycle latency.
        cyc(1, 0, 8'hA0, 4'h0, 0);
        valid_i = 1'b0;
        check("p0 valid_o", 32'(valid_o), 32'h1);
        check("p0 data", 32'(data_o[7:0]), 32'hA0);
        check("p0 level", 32'(level_o[1:0]), 32'h1);
        drain();

        // Port 2 fills at DEPTH; third beat held, then drains in order.
        cyc(1, 2, 8'hC0, 4'h0, 0);
        cyc(1, 2, 8'hC1, 4'h0, 0);
        data_i = 8'hC2;
        #1;
        check("p2 full ready_o", 32'(ready_o), 32'h0);
        check("p2 level full", 32'(level_o[5:4]), 32'h2);
        check("p2 head C0", 32'(data_o[23:16]), 32'hC0);
        cyc(1, 2, 8'hC2, 4'b0100, 0);
        check("p2 head C1", 32'(data_o[23:16]), 32'hC1);
        check("p2 level after pop", 32'(level_o[5:4]), 32'h1);
        cyc(1, 2, 8'hC2, 4'b0100, 0);
        check("p2 head C2", 32'(data_o[23:16]), 32'hC2);
        check("p2 level push+pop", 32'(level_o[5:4]), 32'h1);
        valid_i = 1'b0;
        drain();

        // Simultaneous push and pop on port 1 at level 1.
        cyc(1, 1, 8'hB4, 4'h0, 0);
        cyc(1, 1, 8'hB5, 4'b0010, 0);
        check("p1 level", 32'(level_o[3:2]), 32'h1);
        check("p1 head B5", 32'(data_o[15:8]), 32'hB5);
        valid_i = 1'b0;
        drain();

        // Out-of-range select is accepted and dropped.
        valid_i = 1'b1;
        sel_i   = 3'd5;
        #1;
        check("drop ready_o", 32'(ready_o), 32'h1);
        cyc(1, 5, 8'h55, 4'h0, 0);
        check("drop err_o", 32'(err_o), 32'h1);
        check("drop err_cnt", 32'(err_cnt_o), 32'h1);
        check("drop valid_o", 32'(valid_o), 32'h0);
        cyc(0, 5, 8'h55, 4'h0, 0);
        check("drop err_o low", 32'(err_o), 32'h0);
        for (int i = 0; i < 300; i++) cyc(1, 5, 8'(i), 4'h0, 0);
        valid_i = 1'b0;
        check("drop saturate", 32'(err_cnt_o), 32'hFF);

        // Flush with ports 0 and 3 loaded and a beat offered.
        cyc(1, 0, 8'h10, 4'h0, 0);
        cyc(1, 3, 8'h30, 4'h0, 0);
        valid_i = 1'b1;
        sel_i   = 3'd0;
        flush_i = 1'b1;
        #1;
        check("flush ready_o", 32'(ready_o), 32'h0);
        cyc(1, 0, 8'h11, 4'h0, 1);
        check("flush valid_o", 32'(valid_o), 32'h0);
        check("flush level_o", 32'(level_o), 32'h0);
        check("flush err_cnt", 32'(err_cnt_o), 32'h0);
        flush_i = 1'b0;
        valid_i = 1'b0;

        // Asynchronous reset between edges.
        cyc(1, 1, 8'h71, 4'h0, 0);
        cyc(1, 2, 8'h72, 4'h0, 0);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst valid_o", 32'(valid_o), 32'h0);
        check("async rst level_o", 32'(level_o), 32'h0);
        #1;
        rst = 1'b0;
        cyc(1, 3, 8'hD7, 4'h0, 0);
        valid_i = 1'b0;
        check("post rst valid_o", 32'(valid_o), 32'h8);
        check("post rst data", 32'(data_o[31:24]), 32'hD7);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            automatic int r = int'($urandom_range(0, 9));
            cyc(logic'($urandom_range(0, 3) != 0),
                (r < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7)),
                8'($urandom),
                4'($urandom),
                logic'($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
